// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM and a small
// first-word-fall-through FIFO with sticky framing/overrun status.
module uart_receiver #(
  parameter int unsigned clk_freq_hz = 100000000,
  parameter int unsigned baud_rate   = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_uart_rx,
  output logic [7:0]                       o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count,
  output logic                             o_frame_err,
  output logic                             o_overrun,
  input  logic                             i_clr_err
);

  localparam int unsigned DIV    = clk_freq_hz / baud_rate;
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] HALF_RELOAD = BAUD_W'(DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_RELOAD = BAUD_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic              rx_meta, rx_s;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tick;
  logic              push_req;

  logic load_half, load_full, shift_en, bit_clr, push_set, frame_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, do_pop, do_push, drop;
  logic             frame_err, overrun;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (baud_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    push_set  = 1'b0;
    frame_set = 1'b0;
    unique case (state)
      IDLE:  load_half = !rx_s;
      START: begin
        if (tick && !rx_s) begin
          load_full = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          load_full = 1'b1;
          shift_en  = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          push_set  = rx_s;
          frame_set = !rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      push_req <= 1'b0;
    end else begin
      if (load_half)      baud_cnt <= HALF_RELOAD;
      else if (load_full) baud_cnt <= FULL_RELOAD;
      else if (!tick)     baud_cnt <= baud_cnt - BAUD_W'(1);

      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift <= {rx_s, shift[7:1]};

      push_req <= push_set;
    end
  end

  // The push lands one cycle after the stop sample; the shift register cannot
  // move again until the next frame's data bits, so it is written directly.
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = (count != '0) && i_ready;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem       <= '{default: '0};
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);

      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);

      if (frame_set)      frame_err <= 1'b1;
      else if (i_clr_err) frame_err <= 1'b0;

      if (drop)           overrun <= 1'b1;
      else if (i_clr_err) overrun <= 1'b0;
    end
  end

  assign o_data      = mem[rd_ptr];
  assign o_valid     = (count != '0);
  assign o_count     = count;
  assign o_frame_err = frame_err;
  assign o_overrun   = overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model driven by frame-arrival times.
module tb_uart_receiver;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned BAUD   = 1;
  localparam int unsigned DEPTH  = 4;
  localparam int          LAT    = 155;  // 2 + DIV/2 + 9*DIV + 1 with DIV=16

  logic       clk = 1'b0;
  logic       rst, rx, ready, clr;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       ferr, ovr;

  uart_receiver #(
    .clk_freq_hz(CLK_HZ),
    .baud_rate  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_count    (count),
    .o_frame_err(ferr),
    .o_overrun  (ovr),
    .i_clr_err  (clr)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         nchecks = 0;
  int         nerrors = 0;
  logic [7:0] q[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         m_ferr = 1'b0;
  bit         m_ovr  = 1'b0;
  bit         rand_on;
  int         rdy_pct;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte becomes visible LAT cycles after its start edge, a bad stop
  // bit raises the error one cycle earlier; the FIFO is a plain queue.
  always @(posedge clk) begin
    bit dropped;
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      push_at.delete();
      ferr_at.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      dropped = 1'b0;
      if (ready && q.size() != 0) void'(q.pop_front());
      if (push_at.exists(cyc)) begin
        if (q.size() < DEPTH) q.push_back(push_at[cyc]);
        else dropped = 1'b1;
        push_at.delete(cyc);
      end
      if (ferr_at.exists(cyc)) begin
        m_ferr = 1'b1;
        ferr_at.delete(cyc);
      end else if (clr) m_ferr = 1'b0;
      if (dropped)  m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("valid", valid, int'(q.size() != 0));
      chk("count", count, q.size());
      if (q.size() != 0) chk("data", data, q[0]);
      chk("frame_err", ferr, m_ferr);
      chk("overrun", ovr, m_ovr);
    end
  end

  // Called just after a falling clock edge; the start bit meets the next rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int t0;
    t0 = cyc + 1;
    if (stop) push_at[t0 + LAT] = b;
    else      ferr_at[t0 + LAT - 1] = 1'b1;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_expect(input logic [7:0] b);
    chk("pop_data", data, b);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst = 1'b1; rx = 1'b1; ready = 1'b0; clr = 1'b0;
    rand_on = 1'b0; rdy_pct = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", data, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Exact latency of a clean frame, then a single pop.
    t0 = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_until(t0 + LAT - 1);
        chk("lat_early", valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", valid, 1);
        chk("lat_data", data, 8'hA5);
        chk("lat_count", count, 1);
      end
    join
    pop_expect(8'hA5);
    chk("pop_valid", valid, 0);
    chk("pop_count", count, 0);

    // Short glitch is rejected; next frame is fine.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_valid", valid, 0);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    pop_expect(8'h3C);

    // Bad stop bit followed by a held break.
    send_frame(8'h55, 1'b0);
    repeat (64) @(negedge clk);
    chk("break_ferr", ferr, 1);
    chk("break_count", count, 0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h12, 1'b1);
    repeat (2) @(negedge clk);
    pop_expect(8'h12);
    pulse_clr();
    chk("clr_ferr", ferr, 0);

    // Overrun: fifth byte dropped while full.
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    repeat (3) @(negedge clk);
    chk("ovf_count", count, 4);
    chk("ovf_flag", ovr, 1);
    for (int b = 1; b <= 4; b++) pop_expect(8'(b));
    chk("ovf_empty", valid, 0);
    pulse_clr();
    chk("ovf_clr", ovr, 0);

    // Push coinciding with a pop while full.
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (LAT) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("coin_count", count, 4);
    chk("coin_ovr", ovr, 0);
    for (int b = 2; b <= 5; b++) pop_expect(8'(b));
    chk("coin_empty", valid, 0);

    // Reset during a frame's data bits with state present beforehand.
    send_frame(8'h99, 1'b1);
    send_frame(8'h66, 1'b0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_count", count, 1);
    chk("pre_rst_ferr", ferr, 1);
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_ovr", ovr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    repeat (2) @(negedge clk);
    chk("post_rst_count", count, 1);
    pop_expect(8'h7E);

    // Randomized traffic: bytes, bad stops, glitches, pop/clear patterns.
    rand_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int kind;
          int gap;
          logic [7:0] b;
          case ($urandom_range(0, 2))
            0:       rdy_pct = 0;
            1:       rdy_pct = 3;
            default: rdy_pct = 50;
          endcase
          gap  = $urandom_range(0, 12);
          kind = $urandom_range(0, 9);
          b    = 8'($urandom);
          repeat (gap) @(negedge clk);
          if (kind == 0) begin
            rx = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            rx = 1'b1;
            repeat (12) @(negedge clk);
          end else if (kind == 1) begin
            send_frame(b, 1'b0);
            rx = 1'b1;
            repeat (3) @(negedge clk);
          end else begin
            send_frame(b, 1'b1);
          end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          ready = ($urandom_range(0, 99) < rdy_pct);
          clr   = ($urandom_range(0, 59) == 0);
        end
      end
    join
    ready = 1'b0;
    clr   = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    repeat (8) @(negedge clk);
    ready = 1'b0;
    chk("final_empty", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver; the receive-side counterpart of the SoC's UART emitter.
- Samples the board RXD pin, assembles bytes and buffers them in a small first-word-fall-through FIFO.
- Presents bytes to the SoC IO-page logic through a valid/ready pop interface, plus framing/overrun status.
- Sits beside the emitter in the IO space and runs on the fast board clock.

Parameters:
- clk_freq_hz, 100000000, input clock frequency in Hz.
- baud_rate, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, receive buffer entries; power of two, minimum 2.
- Derived: DIV = clk_freq_hz / baud_rate (integer truncation; 868 at defaults); DIV >= 8 required.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_uart_rx  in  1  serial line; idles high; asynchronous to i_clk.
- o_data  out  8  FIFO head byte; valid only while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  pop request; a pop occurs when o_valid & i_ready at a rising edge.
- o_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- o_frame_err  out  1  sticky; set when a stop bit is sampled low.
- o_overrun  out  1  sticky; set when a byte is dropped because the FIFO is full.
- i_clr_err  in  1  one-cycle pulse; clears both sticky flags. A set event in the same cycle wins.

Behaviour:
- Reset values (asynchronous, i_rst=1):
  - o_valid=0, o_count=0, o_data=0, o_frame_err=0, o_overrun=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, baud counter=0.
- Input path: 2-FF synchronizer on i_uart_rx; all logic uses the second stage (rx_s).
- IDLE:
  - rx_s=0 → load baud counter with DIV/2-1, go to START.
- START:
  - Counter reaches 0 → sample rx_s.
  - Sample 1 → false start, return to IDLE.
  - Sample 0 → reload DIV-1, bit index=0, go to DATA.
- DATA:
  - Each counter expiry samples rx_s into the shift register, LSB first, then reloads DIV-1.
  - After the 8th sample, go to STOP.
- STOP:
  - Sample at expiry.
  - Sample 1 → push byte, go to IDLE.
  - Sample 0 → set o_frame_err, discard byte, go to WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then IDLE. A held break produces no frames.
- Push timing: the byte is written to the FIFO on the cycle after the stop-bit sample.
  - o_valid/o_count update on that same edge, so a byte is visible 1 cycle after the stop sample.
- Total latency from line falling edge to o_valid high: 2 + DIV/2 + 9*DIV + 1 cycles.
- FIFO:
  - First-word-fall-through; o_data is always the head entry.
  - Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - Push when full and no pop in the same cycle → byte dropped, o_overrun set, contents unchanged.
  - Push and pop in the same cycle while full → both performed; count unchanged, no overrun.
  - Push and pop in the same cycle while non-full → count unchanged.
  - Pop while empty → ignored; count stays 0.
- Reset mid-frame: the frame is abandoned. If the line is still low after reset releases, the receiver treats it as a new start edge. A start that fails the mid-bit check is rejected.

Test Plan (clk_freq_hz=16, baud_rate=1, so DIV=16; FIFO_DEPTH=4):
- Frame 0xA5, clean stop bit, line falls at cycle T → o_valid rises at exactly T+155; o_data=0xA5; o_count=1. Pop with i_ready → o_valid=0, o_count=0 next cycle.
- 3-cycle low glitch on RXD, line otherwise idle → no push; o_valid stays 0; receiver back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x55 with stop bit 0, then line held low 64 cycles → o_frame_err=1, o_count=0, no further frames while low. Line high, then frame 0x12 → 0x12 received. i_clr_err → o_frame_err=0.
- Frames 0x01..0x05 back-to-back with no pops → o_count=4, o_overrun=1. Pops return 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
- FIFO full (0x01..0x04), i_ready held so a pop coincides with the 5th byte 0x05's push cycle → o_overrun=0, o_count stays 4. Subsequent pops return 0x02, 0x03, 0x04, 0x05.
- Assert i_rst during the DATA state of a frame → all outputs return to reset values immediately. After release with the line idle high, frame 0x7E is received correctly.
